// File: rtl/fifo_push_arbiter.sv
// Multi-requester push arbiter in front of a FIFO: round-robin or fixed-priority grant,
// registered push/data towards the FIFO, shadow occupancy count and sticky overflow flag.
module fifo_push_arbiter #(
    parameter int unsigned bits  = 16,
    parameter int unsigned depth = 8,
    parameter int unsigned n_req = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [n_req-1:0]             req,
    input  logic [n_req*bits-1:0]        data_in,
    input  logic                         mode,
    output logic [n_req-1:0]             gnt,
    output logic [bits-1:0]              fifo_din,
    output logic                         fifo_push,
    input  logic                         fifo_pop,
    input  logic                         fifo_full,
    output logic [$clog2(depth+1)-1:0]   count,
    output logic                         ovf_err
);

    localparam int unsigned IdxW = $clog2(n_req);
    localparam int unsigned CntW = $clog2(depth + 1);

    logic [IdxW-1:0] ptr;
    logic [IdxW-1:0] win;
    logic            space;
    logic            xfer;
    logic            dec;
    logic [31:0]     cnt_sum;
    logic [CntW-1:0] count_next;

    // Loops run farthest-first so the nearest/lowest candidate is the last one written.
    always_comb begin
        logic [IdxW-1:0] cand;
        win  = '0;
        cand = '0;
        if (mode) begin
            for (int i = n_req - 1; i >= 0; i--) begin
                if (req[i]) win = IdxW'(i);
            end
        end else begin
            for (int unsigned k = n_req; k >= 1; k--) begin
                cand = IdxW'((32'(ptr) + k) % n_req);
                if (req[cand]) win = cand;
            end
        end
    end

    // The pending registered push already occupies a slot.
    assign space = (32'(count) + 32'(fifo_push)) < depth;

    always_comb begin
        gnt = '0;
        if (!rst && space && !fifo_full && (|req)) gnt[win] = 1'b1;
    end

    assign xfer       = |(req & gnt);
    assign dec        = fifo_pop && (count != '0);
    assign cnt_sum    = 32'(count) + 32'(fifo_push) - 32'(dec);
    assign count_next = (cnt_sum > depth) ? CntW'(depth) : CntW'(cnt_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_push <= 1'b0;
            fifo_din  <= '0;
            count     <= '0;
            ovf_err   <= 1'b0;
            ptr       <= IdxW'(n_req - 1);
        end else begin
            fifo_push <= xfer;
            if (xfer) begin
                fifo_din <= data_in[win*bits +: bits];
                ptr      <= win;
            end
            count <= count_next;
            if (fifo_push && fifo_full) ovf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: table-driven fill/credit sequence plus hand-written
// reset, fixed-priority, push/pop and overflow sequences.
module tb_fifo_push_arbiter;

    localparam int unsigned Bits  = 16;
    localparam int unsigned Depth = 8;
    localparam int unsigned NReq  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NReq-1:0]   req;
    logic [NReq*Bits-1:0] data_in;
    logic              mode;
    logic [NReq-1:0]   gnt;
    logic [Bits-1:0]   fifo_din;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic [3:0]        count;
    logic              ovf_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  req;
        logic        mode;
        logic        pop;
        logic        full;
        logic [3:0]  exp_gnt;
        logic        exp_push;
        logic [15:0] exp_din;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs[13];

    fifo_push_arbiter #(
        .bits (Bits),
        .depth(Depth),
        .n_req(NReq)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data_in  (data_in),
        .mode     (mode),
        .gnt      (gnt),
        .fifo_din (fifo_din),
        .fifo_push(fifo_push),
        .fifo_pop (fifo_pop),
        .fifo_full(fifo_full),
        .count    (count),
        .ovf_err  (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic p, input logic [3:0] g,
                                input logic ps, input logic [15:0] d, input logic [3:0] c);
        vec_t v;
        v.req = r; v.mode = 1'b0; v.pop = p; v.full = 1'b0;
        v.exp_gnt = g; v.exp_push = ps; v.exp_din = d; v.exp_cnt = c;
        return v;
    endfunction

    initial begin
        // Round-robin fill to depth, then one credit returned by a single pop.
        vecs[0]  = mk(4'b1111, 1'b0, 4'b0001, 1'b1, 16'hD000, 4'd0);
        vecs[1]  = mk(4'b1111, 1'b0, 4'b0010, 1'b1, 16'hD001, 4'd1);
        vecs[2]  = mk(4'b1111, 1'b0, 4'b0100, 1'b1, 16'hD002, 4'd2);
        vecs[3]  = mk(4'b1111, 1'b0, 4'b1000, 1'b1, 16'hD003, 4'd3);
        vecs[4]  = mk(4'b1111, 1'b0, 4'b0001, 1'b1, 16'hD000, 4'd4);
        vecs[5]  = mk(4'b1111, 1'b0, 4'b0010, 1'b1, 16'hD001, 4'd5);
        vecs[6]  = mk(4'b1111, 1'b0, 4'b0100, 1'b1, 16'hD002, 4'd6);
        vecs[7]  = mk(4'b1111, 1'b0, 4'b1000, 1'b1, 16'hD003, 4'd7);
        vecs[8]  = mk(4'b1111, 1'b0, 4'b0000, 1'b0, 16'hD003, 4'd8);
        vecs[9]  = mk(4'b1111, 1'b0, 4'b0000, 1'b0, 16'hD003, 4'd8);
        vecs[10] = mk(4'b1111, 1'b1, 4'b0000, 1'b0, 16'hD003, 4'd7);
        vecs[11] = mk(4'b1111, 1'b0, 4'b0001, 1'b1, 16'hD000, 4'd7);
        vecs[12] = mk(4'b1111, 1'b0, 4'b0000, 1'b0, 16'hD000, 4'd8);

        data_in   = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        rst       = 1'b1;
        req       = 4'b1111;
        mode      = 1'b0;
        fifo_pop  = 1'b0;
        fifo_full = 1'b0;

        // Reset held two cycles with all requests active.
        for (int c = 0; c < 2; c++) begin
            #1;
            check("rst_gnt", 32'(gnt), 32'h0);
            cyc();
            check("rst_push", 32'(fifo_push), 32'h0);
            check("rst_count", 32'(count), 32'h0);
            check("rst_ovf", 32'(ovf_err), 32'h0);
            check("rst_din", 32'(fifo_din), 32'h0);
        end
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            req = vecs[i].req; mode = vecs[i].mode;
            fifo_pop = vecs[i].pop; fifo_full = vecs[i].full;
            #1;
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
            cyc();
            check($sformatf("vec%0d_push", i), 32'(fifo_push), 32'(vecs[i].exp_push));
            check($sformatf("vec%0d_din", i), 32'(fifo_din), 32'(vecs[i].exp_din));
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
        end
        fifo_pop = 1'b0;
        check("fill_ovf", 32'(ovf_err), 32'h0);

        // Fixed priority: lowest index wins, re-decides in the same cycle req changes.
        rst = 1'b1; cyc(); rst = 1'b0;
        mode = 1'b1; req = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("fp_gnt_0110", 32'(gnt), 32'b0010);
            cyc();
        end
        check("fp_din", 32'(fifo_din), 32'hD001);
        req = 4'b0100;
        #1;
        check("fp_gnt_0100", 32'(gnt), 32'b0100);
        cyc();
        check("fp_din2", 32'(fifo_din), 32'hD002);
        req = 4'b0000;
        #1;
        check("idle_gnt", 32'(gnt), 32'h0);
        cyc();
        req = 4'b0100; fifo_full = 1'b1;
        #1;
        check("full_gnt", 32'(gnt), 32'h0);
        cyc();
        fifo_full = 1'b0;
        check("full_nopush", 32'(fifo_push), 32'h0);

        // Push and pop on the same edge leave count unchanged; pop at empty is ignored.
        rst = 1'b1; cyc(); rst = 1'b0;
        mode = 1'b0; req = 4'b0001;
        for (int c = 0; c < 4; c++) cyc();
        check("pp_count3", 32'(count), 32'd3);
        check("pp_push", 32'(fifo_push), 32'h1);
        req = 4'b0000; fifo_pop = 1'b1;
        cyc();
        check("pp_same", 32'(count), 32'd3);
        for (int c = 2; c >= 0; c--) begin
            cyc();
            check("pp_drain", 32'(count), 32'(c));
        end
        cyc();
        check("pp_empty_pop", 32'(count), 32'd0);
        fifo_pop = 1'b0;

        // Reset with a push in flight discards it and restarts arbitration at requester 0.
        rst = 1'b1; cyc(); rst = 1'b0;
        req = 4'b1111;
        for (int c = 0; c < 6; c++) cyc();
        check("mr_count5", 32'(count), 32'd5);
        check("mr_inflight", 32'(fifo_push), 32'h1);
        rst = 1'b1;
        #1;
        check("mr_rst_gnt", 32'(gnt), 32'h0);
        cyc();
        rst = 1'b0;
        check("mr_push", 32'(fifo_push), 32'h0);
        check("mr_count", 32'(count), 32'h0);
        #1;
        check("mr_first_gnt", 32'(gnt), 32'b0001);

        // Overflow: push lands while the FIFO reports full; flag is sticky until reset.
        cyc();
        fifo_full = 1'b1;
        #1;
        check("ovf_gnt", 32'(gnt), 32'h0);
        cyc();
        check("ovf_set", 32'(ovf_err), 32'h1);
        fifo_full = 1'b0; req = 4'b0000;
        cyc(); cyc();
        check("ovf_sticky", 32'(ovf_err), 32'h1);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("ovf_clr", 32'(ovf_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
